multicycle_ctrl_fsm: RTL

MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

---
 rtl/multicycle_ctrl_fsm.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle processor control unit.
// The state register and multiply counter form one clocked block; the control
// strobes are decoded from the current state (plus MemReady in FETCH), so
// every strobe is aligned with the state it belongs to.
module multicycle_ctrl_fsm #(
  parameter int unsigned MUL_CYCLES  = 4,    // cycles spent in MULEXEC, 1..16
  parameter bit          MEM_WAIT_EN = 1'b1  // 0: memory is always ready
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       IsMul,
  input  logic       MemReady,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       NextPC,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       ALUOp,
  output logic       MulEn,
  output logic       LinkW,
  output logic       Fault,
  output logic       MulBusy,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_MULEXEC  = 4'd8,
    S_ALUWB    = 4'd9,
    S_BRLINK   = 4'd10,
    S_BRANCH   = 4'd11,
    S_UNKNOWN  = 4'd12
  } state_t;

  // Counter preload: MULEXEC exits when the counter reaches zero, so the
  // state lasts exactly MUL_CYCLES cycles (one cycle when MUL_CYCLES is 1).
  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic       mem_ready_s;

  // Only three instruction bits steer the control flow; the rest are sunk.
  logic       unused_funct_s;
  assign unused_funct_s = ^Funct[3:1];

  // Memory handshake; with waiting disabled the memory is always ready.
  assign mem_ready_s = MEM_WAIT_EN ? MemReady : 1'b1;

  // Next-state and multiply-counter logic.
  always_comb begin
    state_d   = state_q;
    mul_cnt_d = mul_cnt_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_s) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (Op)
          2'b00: begin
            // Multiply decode wins over the immediate bit.
            if (IsMul) begin
              state_d   = S_MULEXEC;
              mul_cnt_d = MUL_LOAD;
            end else if (Funct[5]) begin
              state_d = S_EXECUTEI;
            end else begin
              state_d = S_EXECUTER;
            end
          end
          2'b01: begin
            state_d = S_MEMADR;
          end
          2'b10: begin
            if (Funct[4]) begin
              state_d = S_BRLINK;
            end else begin
              state_d = S_BRANCH;
            end
          end
          default: begin
            state_d = S_UNKNOWN;
          end
        endcase
      end
      S_MEMADR: begin
        if (Funct[0]) begin
          state_d = S_MEMREAD;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMREAD: begin
        if (mem_ready_s) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWRITE: begin
        if (mem_ready_s) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_MEMWB: begin
        state_d = S_FETCH;
      end
      S_EXECUTER: begin
        state_d = S_ALUWB;
      end
      S_EXECUTEI: begin
        state_d = S_ALUWB;
      end
      S_MULEXEC: begin
        if (mul_cnt_q == 4'd0) begin
          state_d = S_ALUWB;
        end else begin
          state_d   = S_MULEXEC;
          mul_cnt_d = mul_cnt_q - 4'd1;
        end
      end
      S_ALUWB: begin
        state_d = S_FETCH;
      end
      S_BRLINK: begin
        state_d = S_BRANCH;
      end
      S_BRANCH: begin
        state_d = S_FETCH;
      end
      S_UNKNOWN: begin
        state_d = S_FETCH;
      end
      default: begin
        state_d   = S_FETCH;
        mul_cnt_d = 4'd0;
      end
    endcase
  end

  // State register and multiply counter; reset wins from any state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      mul_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  // Control strobes decoded from the current state.
  always_comb begin
    IRWrite   = 1'b0;
    AdrSrc    = 1'b0;
    NextPC    = 1'b0;
    RegW      = 1'b0;
    MemW      = 1'b0;
    Branch    = 1'b0;
    ALUOp     = 1'b0;
    MulEn     = 1'b0;
    LinkW     = 1'b0;
    Fault     = 1'b0;
    MulBusy   = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state_q)
      S_FETCH: begin
        // Instruction register and PC commit only once memory delivers.
        IRWrite   = mem_ready_s;
        NextPC    = mem_ready_s;
        ResultSrc = 2'b10;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
      end
      S_DECODE: begin
        ResultSrc = 2'b10;
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
      end
      S_MEMADR: begin
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc = 1'b1;
        MemW   = 1'b1;
      end
      S_MEMWB: begin
        RegW      = 1'b1;
        ResultSrc = 2'b01;
      end
      S_EXECUTER: begin
        ALUSrcB = 2'b00;
        ALUOp   = 1'b1;
      end
      S_EXECUTEI: begin
        ALUSrcB = 2'b01;
        ALUOp   = 1'b1;
      end
      S_MULEXEC: begin
        MulEn   = 1'b1;
        MulBusy = 1'b1;
      end
      S_ALUWB: begin
        RegW      = 1'b1;
        ResultSrc = 2'b00;
      end
      S_BRLINK: begin
        // Link register receives PC+4.
        RegW      = 1'b1;
        LinkW     = 1'b1;
        ResultSrc = 2'b10;
      end
      S_BRANCH: begin
        Branch    = 1'b1;
        ResultSrc = 2'b10;
        ALUSrcB   = 2'b01;
      end
      S_UNKNOWN: begin
        Fault = 1'b1;
      end
      default: begin
        Fault = 1'b0;
      end
    endcase
  end

endmodule
